// File: rtl/iopmp_stimulus_gen.sv
// Register-programmed stimulus generator: launches one IOPMP check and records the verdict.
// Optional response timeout: define IOPMP_STIMULUS_TIMEOUT_EN.
module iopmp_stimulus_gen #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_req_i,
  input  logic        reg_we_i,
  input  logic [15:0] reg_addr_i,
  input  logic [63:0] reg_wdata_i,
  output logic [63:0] reg_rdata_o,
  output logic        reg_ready_o,
  output logic        reg_error_o,
  output logic        chk_valid_o,
  input  logic        chk_ready_i,
  output logic [63:0] chk_addr_o,
  output logic [63:0] chk_wdata_o,
  output logic [13:0] chk_sid_o,
  output logic [1:0]  chk_access_o,
  input  logic        chk_rsp_valid_i,
  input  logic        chk_rsp_allow_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } state_t;

  localparam logic [15:0] OFF_CFG    = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0008;
  localparam logic [15:0] OFF_DATA   = 16'h0010;
  localparam logic [15:0] OFF_ADDR   = 16'h0018;

  state_t      r_state;
  state_t      w_next;
  logic        r_en;
  logic [13:0] r_sid;
  logic [1:0]  r_acc;
  logic [63:0] r_data;
  logic [63:0] r_addr;
  logic        r_tr;

  logic        w_hitCfg;
  logic        w_hitStatus;
  logic        w_hitData;
  logic        w_hitAddr;
  logic        w_mapped;
  logic        w_busy;
  logic        w_reject;
  logic        w_wrOk;
  logic        w_launch;
  logic        w_expired;
  logic        w_chkValid;
  logic        w_toDone;
  logic [63:0] w_rdata;

  assign w_hitCfg    = (reg_addr_i == OFF_CFG);
  assign w_hitStatus = (reg_addr_i == OFF_STATUS);
  assign w_hitData   = (reg_addr_i == OFF_DATA);
  assign w_hitAddr   = (reg_addr_i == OFF_ADDR);
  assign w_mapped    = w_hitCfg | w_hitStatus | w_hitData | w_hitAddr;

  // Anything outside IDLE owns the transaction registers, so writes bounce until back in IDLE.
  assign w_busy   = (r_state != IDLE);
  assign w_reject = !w_mapped || (reg_we_i && (w_hitStatus || w_busy));
  assign w_wrOk   = reg_req_i && reg_we_i && !w_reject;
  assign w_launch = w_wrOk && w_hitCfg && reg_wdata_i[63];

  assign reg_ready_o = reg_req_i;
  assign reg_error_o = reg_req_i && w_reject && !rst_i;
  assign reg_rdata_o = w_rdata;

  always_comb begin
    w_rdata = '0;
    if (!rst_i && !w_reject) begin
      if (w_hitCfg)         w_rdata = {r_en, 47'd0, r_sid, r_acc};
      else if (w_hitStatus) w_rdata = {63'd0, r_tr};
      else if (w_hitData)   w_rdata = r_data;
      else if (w_hitAddr)   w_rdata = r_addr;
    end
  end

`ifdef IOPMP_STIMULUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] r_toCnt;

  // Counts completed WAIT_RSP cycles; expiry fires in the last permitted cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_toCnt <= '0;
    end else if (r_state == WAIT_RSP && w_next == WAIT_RSP) begin
      r_toCnt <= r_toCnt + CW'(1);
    end else begin
      r_toCnt <= '0;
    end
  end

  assign w_expired = (r_state == WAIT_RSP) && (r_toCnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_chkValid = 1'b0;
    w_toDone   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_next = (reg_wdata_i[1:0] == 2'b00) ? DONE : REQ;
        end
      end
      REQ: begin
        w_chkValid = 1'b1;
        if (chk_ready_i) begin
          w_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (chk_rsp_valid_i || w_expired) begin
          w_next   = DONE;
          w_toDone = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // EN drops on the verdict edge so software sees EN=0 together with a valid TR.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en   <= 1'b0;
      r_sid  <= '0;
      r_acc  <= '0;
      r_data <= '0;
      r_addr <= '0;
      r_tr   <= 1'b0;
    end else begin
      if (w_wrOk && w_hitData) begin
        r_data <= reg_wdata_i;
      end
      if (w_wrOk && w_hitAddr) begin
        r_addr <= reg_wdata_i;
      end
      if (w_wrOk && w_hitCfg) begin
        r_sid <= reg_wdata_i[15:2];
        r_acc <= reg_wdata_i[1:0];
      end
      if (w_launch) begin
        r_en <= 1'b1;
      end else if (w_toDone || r_state == DONE) begin
        r_en <= 1'b0;
      end
      if (w_launch) begin
        r_tr <= 1'b0;
      end else if (r_state == WAIT_RSP && chk_rsp_valid_i) begin
        r_tr <= chk_rsp_allow_i;
      end else if (w_expired) begin
        r_tr <= 1'b0;
      end
    end
  end

  assign chk_valid_o  = w_chkValid;
  assign chk_addr_o   = r_addr;
  assign chk_wdata_o  = r_data;
  assign chk_sid_o    = r_sid;
  assign chk_access_o = r_acc;

endmodule

// File: tb/tb_iopmp_stimulus_gen.sv
// Bench for iopmp_stimulus_gen: directed scenarios plus randomized launches against a register-level model.
// Timeout scenarios run only when IOPMP_STIMULUS_TIMEOUT_EN is defined.
module tb_iopmp_stimulus_gen;

  localparam logic [15:0] OFF_CFG    = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0008;
  localparam logic [15:0] OFF_DATA   = 16'h0010;
  localparam logic [15:0] OFF_ADDR   = 16'h0018;
  localparam logic [15:0] OFF_BAD    = 16'h0020;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        reg_req_i;
  logic        reg_we_i;
  logic [15:0] reg_addr_i;
  logic [63:0] reg_wdata_i;
  logic [63:0] reg_rdata_o;
  logic        reg_ready_o;
  logic        reg_error_o;
  logic        chk_valid_o;
  logic        chk_ready_i;
  logic [63:0] chk_addr_o;
  logic [63:0] chk_wdata_o;
  logic [13:0] chk_sid_o;
  logic [1:0]  chk_access_o;
  logic        chk_rsp_valid_i;
  logic        chk_rsp_allow_i;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  always #5 clk_i = ~clk_i;

  iopmp_stimulus_gen #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .reg_req_i      (reg_req_i),
    .reg_we_i       (reg_we_i),
    .reg_addr_i     (reg_addr_i),
    .reg_wdata_i    (reg_wdata_i),
    .reg_rdata_o    (reg_rdata_o),
    .reg_ready_o    (reg_ready_o),
    .reg_error_o    (reg_error_o),
    .chk_valid_o    (chk_valid_o),
    .chk_ready_i    (chk_ready_i),
    .chk_addr_o     (chk_addr_o),
    .chk_wdata_o    (chk_wdata_o),
    .chk_sid_o      (chk_sid_o),
    .chk_access_o   (chk_access_o),
    .chk_rsp_valid_i(chk_rsp_valid_i),
    .chk_rsp_allow_i(chk_rsp_allow_i)
  );

  // Spec-level view of CFG readback: EN, zeros, SID and A taken from the written word.
  function automatic logic [63:0] cfgView(input logic en, input logic [63:0] word);
    return {en, 47'd0, word[15:2], word[1:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One register access cycle; entered and left just after a rising edge.
  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                               output logic [63:0] rdata, output logic err, output logic rdy);
    reg_req_i   = 1'b1;
    reg_we_i    = we;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    @(negedge clk_i);
    rdata = reg_rdata_o;
    err   = reg_error_o;
    rdy   = reg_ready_o;
    @(posedge clk_i);
    #1;
    reg_req_i = 1'b0;
    reg_we_i  = 1'b0;
  endtask

  task automatic regWrite(input logic [15:0] addr, input logic [63:0] wdata, input logic expErr, input string tag);
    logic [63:0] rd;
    logic        er;
    logic        rdy;
    applyStimulus(1'b1, addr, wdata, rd, er, rdy);
    checkOutput({tag, "_err"}, 64'(er), 64'(expErr));
  endtask

  task automatic regRead(input logic [15:0] addr, input logic [63:0] expData, input string tag);
    logic [63:0] rd;
    logic        er;
    logic        rdy;
    applyStimulus(1'b0, addr, 64'd0, rd, er, rdy);
    checkOutput({tag, "_rdata"}, rd, expData);
    checkOutput({tag, "_err"}, 64'(er), 64'd0);
    checkOutput({tag, "_ready"}, 64'(rdy), 64'd1);
  endtask

  task automatic checkIdle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      checkOutput({tag, "_valid"}, 64'(chk_valid_o), 64'd0);
      checkOutput({tag, "_ready"}, 64'(reg_ready_o), 64'd0);
      @(posedge clk_i);
      #1;
    end
  endtask

  // Request phase: ready held low for 'delay' cycles, stray responses driven throughout must be ignored.
  task automatic reqPhase(input int delay, input logic [63:0] eAddr, input logic [63:0] eData,
                          input logic [13:0] eSid, input logic [1:0] eAcc, input string tag);
    for (int d = 0; d <= delay; d++) begin
      chk_ready_i     = (d == delay);
      chk_rsp_valid_i = 1'($urandom_range(0, 1));
      chk_rsp_allow_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      checkOutput({tag, "_valid"}, 64'(chk_valid_o), 64'd1);
      checkOutput({tag, "_addr"},  chk_addr_o, eAddr);
      checkOutput({tag, "_wdata"}, chk_wdata_o, eData);
      checkOutput({tag, "_sid"},   64'(chk_sid_o), 64'(eSid));
      checkOutput({tag, "_acc"},   64'(chk_access_o), 64'(eAcc));
      @(posedge clk_i);
      #1;
    end
    chk_ready_i     = 1'b0;
    chk_rsp_valid_i = 1'b0;
    chk_rsp_allow_i = 1'b0;
  endtask

  task automatic waitPhase(input int delay, input logic allow, input string tag);
    for (int d = 0; d <= delay; d++) begin
      chk_rsp_valid_i = (d == delay);
      chk_rsp_allow_i = allow;
      @(negedge clk_i);
      checkOutput({tag, "_wvalid"}, 64'(chk_valid_o), 64'd0);
      @(posedge clk_i);
      #1;
    end
    chk_rsp_valid_i = 1'b0;
    chk_rsp_allow_i = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    logic        rdy;
    logic [63:0] mData;
    logic [63:0] mAddr;
    logic [63:0] junk;
    logic [63:0] word;
    logic [13:0] rSid;
    logic [1:0]  rAcc;
    logic        allow;
    int          rdyD;
    int          rspD;

    rst_i           = 1'b1;
    reg_req_i       = 1'b0;
    reg_we_i        = 1'b0;
    reg_addr_i      = '0;
    reg_wdata_i     = '0;
    chk_ready_i     = 1'b0;
    chk_rsp_valid_i = 1'b0;
    chk_rsp_allow_i = 1'b0;

    @(negedge clk_i);
    checkOutput("rst_valid", 64'(chk_valid_o), 64'd0);
    checkOutput("rst_err",   64'(reg_error_o), 64'd0);
    checkOutput("rst_rdata", reg_rdata_o, 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    regRead(OFF_CFG,    64'd0, "rst_cfg");
    regRead(OFF_STATUS, 64'd0, "rst_status");
    regRead(OFF_DATA,   64'd0, "rst_data");
    regRead(OFF_ADDR,   64'd0, "rst_addr");
    checkIdle(1, "rst_idle");

    // Allowed transaction, checker ready immediately, verdict two cycles after handshake.
    regWrite(OFF_ADDR, 64'h0000_0000_8000_1000, 1'b0, "t1_waddr");
    regWrite(OFF_CFG,  64'h8000_0000_0000_0015, 1'b0, "t1_launch");
    reqPhase(0, 64'h0000_0000_8000_1000, 64'd0, 14'd5, 2'd1, "t1_req");
    waitPhase(1, 1'b1, "t1");
    regRead(OFF_STATUS, 64'd1, "t1_status");
    regRead(OFF_CFG, 64'h0000_0000_0000_0015, "t1_cfg");

    // A=0 launch bypasses the checker and leaves TR cleared.
    regWrite(OFF_CFG, 64'h8000_0000_0000_0028, 1'b0, "t2_launch");
    checkIdle(1, "t2_skip");
    regRead(OFF_CFG, 64'h0000_0000_0000_0028, "t2_cfg");
    regRead(OFF_STATUS, 64'd0, "t2_status");

    // Slow checker and deny verdict; busy writes and bad offsets are rejected meanwhile.
    regWrite(OFF_DATA, 64'hDEAD_BEEF_0123_4567, 1'b0, "t3_wdata");
    regWrite(OFF_CFG,  64'h8000_0000_0000_0015, 1'b0, "t3_launch");
    reqPhase(4, 64'h0000_0000_8000_1000, 64'hDEAD_BEEF_0123_4567, 14'd5, 2'd1, "t3_req");
    regWrite(OFF_DATA, 64'h1111_2222_3333_4444, 1'b1, "t3_busy_data");
    regWrite(OFF_CFG,  64'h0000_0000_0000_0002, 1'b1, "t3_busy_cfg");
    applyStimulus(1'b0, OFF_BAD, 64'd0, rd, er, rdy);
    checkOutput("t3_bad_rdata", rd, 64'd0);
    checkOutput("t3_bad_err", 64'(er), 64'd1);
    regRead(OFF_CFG, 64'h8000_0000_0000_0015, "t3_busy_rcfg");
    regWrite(OFF_STATUS, 64'd1, 1'b1, "t3_wstatus");
    waitPhase(0, 1'b0, "t3");
    regRead(OFF_STATUS, 64'd0, "t3_status");
    regRead(OFF_DATA, 64'hDEAD_BEEF_0123_4567, "t3_data_kept");
    regRead(OFF_CFG, 64'h0000_0000_0000_0015, "t3_cfg");
    regWrite(OFF_BAD, 64'hFFFF, 1'b1, "t3_wbad");
    regRead(OFF_DATA, 64'hDEAD_BEEF_0123_4567, "t3_data_kept2");

`ifdef IOPMP_STIMULUS_TIMEOUT_EN
    // No verdict: eight WAIT_RSP cycles then DONE with TR=0.
    regWrite(OFF_CFG, 64'h8000_0000_0000_0007, 1'b0, "to1_launch");
    reqPhase(0, 64'h0000_0000_8000_1000, 64'hDEAD_BEEF_0123_4567, 14'd1, 2'd3, "to1_req");
    for (int k = 0; k < 8; k++) begin
      regRead(OFF_CFG, 64'h8000_0000_0000_0007, "to1_wait_cfg");
    end
    regRead(OFF_CFG, 64'h0000_0000_0000_0007, "to1_done_cfg");
    regRead(OFF_STATUS, 64'd0, "to1_status");
    // Verdict in the eighth cycle wins over expiry.
    regWrite(OFF_CFG, 64'h8000_0000_0000_0007, 1'b0, "to2_launch");
    reqPhase(0, 64'h0000_0000_8000_1000, 64'hDEAD_BEEF_0123_4567, 14'd1, 2'd3, "to2_req");
    waitPhase(7, 1'b1, "to2");
    regRead(OFF_STATUS, 64'd1, "to2_status");
`endif

    // Randomized launches; the model holds the register values software last wrote.
    for (int it = 0; it < 12; it++) begin
      mData = {$urandom, $urandom};
      mAddr = {$urandom, $urandom};
      junk  = {$urandom, $urandom};
      rSid  = 14'($urandom);
      rAcc  = (it % 4 == 3) ? 2'd0 : 2'($urandom);
      allow = 1'($urandom_range(0, 1));
      rdyD  = int'($urandom_range(0, 4));
      rspD  = int'($urandom_range(0, 4));

      regWrite(OFF_DATA, mData, 1'b0, "rnd_wdata");
      regWrite(OFF_ADDR, mAddr, 1'b0, "rnd_waddr");
      word = {1'b0, junk[62:16], ~rSid, ~rAcc};
      regWrite(OFF_CFG, word, 1'b0, "rnd_wcfg0");
      regRead(OFF_CFG, cfgView(1'b0, word), "rnd_rcfg0");
      word = {1'b1, junk[62:16], rSid, rAcc};
      regWrite(OFF_CFG, word, 1'b0, "rnd_launch");

      if (rAcc == 2'd0) begin
        checkIdle(1, "rnd_skip");
        regRead(OFF_CFG, cfgView(1'b0, word), "rnd_skip_cfg");
        regRead(OFF_STATUS, 64'd0, "rnd_skip_status");
      end else begin
        reqPhase(rdyD, mAddr, mData, rSid, rAcc, "rnd_req");
        if (rspD > 0) begin
          regWrite(OFF_DATA, ~mData, 1'b1, "rnd_busy_data");
          waitPhase(rspD - 1, allow, "rnd");
        end else begin
          waitPhase(0, allow, "rnd");
        end
        regRead(OFF_STATUS, 64'(allow), "rnd_status");
        regRead(OFF_CFG, cfgView(1'b0, word), "rnd_cfg");
        regRead(OFF_DATA, mData, "rnd_data");
        regRead(OFF_ADDR, mAddr, "rnd_addr");
      end
    end

    // Reset in WAIT_RSP clears everything; a late verdict afterwards is ignored.
    regWrite(OFF_DATA, 64'h0123_4567_89AB_CDEF, 1'b0, "rs_wdata");
    regWrite(OFF_ADDR, 64'h0000_0000_9000_2000, 1'b0, "rs_waddr");
    regWrite(OFF_CFG,  64'h8000_0000_0000_000E, 1'b0, "rs_launch");
    reqPhase(1, 64'h0000_0000_9000_2000, 64'h0123_4567_89AB_CDEF, 14'd3, 2'd2, "rs_req");
    checkIdle(1, "rs_wait");
    rst_i      = 1'b1;
    reg_req_i  = 1'b1;
    reg_we_i   = 1'b0;
    reg_addr_i = OFF_BAD;
    @(negedge clk_i);
    checkOutput("rs_in_valid", 64'(chk_valid_o), 64'd0);
    checkOutput("rs_in_err",   64'(reg_error_o), 64'd0);
    checkOutput("rs_in_rdata", reg_rdata_o, 64'd0);
    reg_addr_i = OFF_DATA;
    #1;
    checkOutput("rs_in_rdata_data", reg_rdata_o, 64'd0);
    @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    reg_req_i = 1'b0;
    chk_rsp_valid_i = 1'b1;
    chk_rsp_allow_i = 1'b1;
    @(negedge clk_i);
    checkOutput("rs_late_valid", 64'(chk_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    chk_rsp_valid_i = 1'b0;
    chk_rsp_allow_i = 1'b0;
    regRead(OFF_STATUS, 64'd0, "rs_status");
    regRead(OFF_CFG,    64'd0, "rs_cfg");
    regRead(OFF_DATA,   64'd0, "rs_data");
    regRead(OFF_ADDR,   64'd0, "rs_addr");
    checkIdle(2, "rs_idle");

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
